// File: rtl/ras_ckpt.sv
// ras_ckpt -- return-address stack with multi-level branch checkpointing.
//
// Calls push a return address and returns pop it. Each predicted branch
// snapshots the post-operation stack state {tos, count, dout} into a small
// FIFO. Branches resolve in order: close_valid drops the oldest snapshot,
// close_invalid rolls the stack back to it and flushes every snapshot.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst_n          synchronous active-low reset
//   push, din      call: push din
//   pop            return: pop top of stack
//   dout           registered top-of-stack (predicted return address)
//   empty          registered, stack holds zero valid entries
//   branch         allocate a checkpoint of the post-operation state
//   close_valid    oldest outstanding branch predicted correctly
//   close_invalid  oldest outstanding branch mispredicted (restore)
//   ckpt_full      registered, NCKPT checkpoints outstanding
//   ckpt_ovf       sticky, branch dropped because the FIFO was full
//
// No handshakes: every input is acted on in the cycle it is sampled.

module ras_ckpt #(
   parameter int DEPTH  = 1024,
   parameter int WIDTH  = 32,
   parameter int ADDR   = $clog2(DEPTH),
   parameter int NCKPT  = 8,
   parameter int CKADDR = $clog2(NCKPT)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   input  logic             branch,
   input  logic             close_valid,
   input  logic             close_invalid,
   output logic             ckpt_full,
   output logic             ckpt_ovf
);

   localparam logic [ADDR:0]   CNT_MAX = (ADDR+1)'(DEPTH);
   localparam logic [CKADDR:0] OCC_MAX = (CKADDR+1)'(NCKPT);

   // Stack storage, never reset: count alone defines which entries are live.
   logic [WIDTH-1:0] mem [DEPTH];

   logic [ADDR-1:0]   tos_q, tos_d;
   logic [ADDR:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]  dout_q, dout_d;
   logic              empty_q;

   // Checkpoint FIFO
   logic [ADDR-1:0]   ck_tos_q  [NCKPT];
   logic [ADDR:0]     ck_cnt_q  [NCKPT];
   logic [WIDTH-1:0]  ck_dout_q [NCKPT];
   logic [CKADDR-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CKADDR:0]   occ_q, occ_d, occ_mid;
   logic              full_q, ovf_q, ovf_d;
   logic              ck_we;

   // Single stack write port shared by push/replace and restore repair
   logic              mem_we;
   logic [ADDR-1:0]   mem_wa;
   logic [WIDTH-1:0]  mem_wd;

   logic              restore;
   logic [ADDR-1:0]   tos_p1, tos_m1;

   assign tos_p1  = tos_q + 1'b1;
   assign tos_m1  = tos_q - 1'b1;
   assign restore = close_invalid && (occ_q != '0);

   always_comb begin
      tos_d   = tos_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      occ_d   = occ_q;
      occ_mid = occ_q;
      ovf_d   = ovf_q;
      ck_we   = 1'b0;
      mem_we  = 1'b0;
      mem_wa  = tos_q;
      mem_wd  = din;

      if (restore) begin
         // Roll back to the oldest snapshot; push, pop and branch are dropped.
         tos_d  = ck_tos_q[rd_q];
         cnt_d  = ck_cnt_q[rd_q];
         dout_d = ck_dout_q[rd_q];
         // Rewrite the saved TOS slot in case a pop-then-push clobbered it.
         mem_we = 1'b1;
         mem_wa = ck_tos_q[rd_q];
         mem_wd = ck_dout_q[rd_q];
         occ_d  = '0;
         wr_d   = rd_q;
      end else begin
         if (push && (!pop || cnt_q == '0)) begin
            // Plain push (or push+pop on an empty stack). When full, the
            // oldest entry is overwritten and count stays saturated.
            tos_d  = tos_p1;
            mem_we = 1'b1;
            mem_wa = tos_p1;
            dout_d = din;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
         end else if (push && pop) begin
            // Replace the top entry in place.
            mem_we = 1'b1;
            mem_wa = tos_q;
            dout_d = din;
         end else if (pop && cnt_q != '0) begin
            tos_d  = tos_m1;
            dout_d = mem[tos_m1];
            cnt_d  = cnt_q - 1'b1;
         end

         // Release happens before allocation so a full FIFO can still take
         // a branch that arrives together with close_valid.
         if (close_valid && occ_q != '0) begin
            rd_d    = rd_q + 1'b1;
            occ_mid = occ_q - 1'b1;
         end
         occ_d = occ_mid;

         if (branch) begin
            if (occ_mid != OCC_MAX) begin
               ck_we = 1'b1;
               wr_d  = wr_q + 1'b1;
               occ_d = occ_mid + 1'b1;
            end else begin
               ovf_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tos_q   <= '1;
         cnt_q   <= '0;
         dout_q  <= '0;
         empty_q <= 1'b1;
         wr_q    <= '0;
         rd_q    <= '0;
         occ_q   <= '0;
         full_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         tos_q   <= tos_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         empty_q <= (cnt_d == '0);
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         occ_q   <= occ_d;
         full_q  <= (occ_d == OCC_MAX);
         ovf_q   <= ovf_d;
      end
   end

   // Snapshot payload captures the post-operation state.
   always_ff @(posedge clk) begin
      if (rst_n && ck_we) begin
         ck_tos_q[wr_q]  <= tos_d;
         ck_cnt_q[wr_q]  <= cnt_d;
         ck_dout_q[wr_q] <= dout_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && mem_we) begin
         mem[mem_wa] <= mem_wd;
      end
   end

   assign dout      = dout_q;
   assign empty     = empty_q;
   assign ckpt_full = full_q;
   assign ckpt_ovf  = ovf_q;

endmodule
